// File: rtl/mk_sized_fifo.sv
// Parametrised synchronous FIFO with guarded enqueue/dequeue and optional
// pipeline (enqueue-when-full) and bypass (dequeue-when-empty) modes.
module mk_sized_fifo #(
    parameter int unsigned width  = 1,
    parameter int unsigned depth  = 2,
    parameter bit          pipe   = 1'b0,
    parameter bit          bypass = 1'b0,
    localparam int unsigned CW    = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enq_en,
    input  logic [width-1:0] enq_data,
    input  logic             deq_en,
    output logic [width-1:0] first,
    output logic             not_full,
    output logic             not_empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [2*width-1:0] PAT_REP = {width{2'b10}};
    localparam logic [width-1:0] INIT_PAT = PAT_REP[2*width-1 -: width];

    // Storage is deliberately not reset; the initialiser only gives simulation a known pattern.
    logic [width-1:0] mem [depth] = '{default: INIT_PAT};
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    logic full;
    logic empty;
    logic do_enq;
    logic do_deq;
    logic pass_through;
    logic wr;
    logic rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    // Acceptance, data output and effective-transfer decode.
    always_comb begin
        full         = (count == CW'(depth));
        empty        = (count == '0);
        not_full     = !full || (pipe && deq_en && !empty);
        not_empty    = !empty || (bypass && enq_en);
        first        = (empty && bypass) ? enq_data : mem[head];
        do_enq       = enq_en && not_full;
        do_deq       = deq_en && not_empty;
        pass_through = empty && bypass && do_enq && do_deq;
        wr           = do_enq && !pass_through;
        rd           = do_deq && !pass_through;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) tail <= ptr_inc(tail);
            if (rd) head <= ptr_inc(head);
            if (wr && !rd) count <= count + CW'(1);
            else if (rd && !wr) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear && wr) mem[tail] <= enq_data;
    end

endmodule

// File: tb/tb_mk_sized_fifo.sv
// Bench for mk_sized_fifo: five configurations share one stimulus stream and
// are each checked every cycle against a shift-array occupancy model.
module tb_mk_sized_fifo;

    localparam int NI = 5;
    localparam int unsigned DEP [NI] = '{3, 2, 2, 4, 1};
    localparam bit          PIP [NI] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam bit          BYP [NI] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       enq_en = 1'b0;
    logic       deq_en = 1'b0;
    logic [7:0] enq_data = 8'h00;

    logic [7:0] f_o  [NI];
    logic       nf_o [NI];
    logic       ne_o [NI];
    logic [2:0] c_o  [NI];

    int n_vec = 0;
    int n_err = 0;

    // Model: entry 0 is the head; mc is the occupancy.
    logic [7:0] md [NI][4];
    int         mc [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int unsigned D = DEP[g];
        logic [$clog2(D+1)-1:0] c;
        mk_sized_fifo #(.width(8), .depth(D), .pipe(PIP[g]), .bypass(BYP[g])) u (
            .clk(clk), .rst_n(rst_n), .clear(clear),
            .enq_en(enq_en), .enq_data(enq_data), .deq_en(deq_en),
            .first(f_o[g]), .not_full(nf_o[g]), .not_empty(ne_o[g]), .count(c)
        );
        assign c_o[g] = 3'(c);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_nf(input int i);
        return (mc[i] < int'(DEP[i])) || (PIP[i] && deq_en && mc[i] > 0);
    endfunction

    function automatic bit m_ne(input int i);
        return (mc[i] > 0) || (BYP[i] && enq_en);
    endfunction

    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            bit e, d;
            if (!rst_n || clear) begin
                mc[i] = 0;
            end else begin
                e = enq_en && m_nf(i);
                d = deq_en && m_ne(i);
                if (!(mc[i] == 0 && BYP[i] && e && d)) begin
                    if (d) begin
                        for (int k = 0; k < 3; k++) md[i][k] = md[i][k+1];
                        mc[i]--;
                    end
                    if (e) begin
                        md[i][mc[i]] = enq_data;
                        mc[i]++;
                    end
                end
            end
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    initial begin
        for (int i = 0; i < NI; i++) mc[i] = 0;
        @(posedge clk);
        model_update();
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d count", i), int'(c_o[i]), mc[i]);
                chk($sformatf("u%0d not_full", i), int'(nf_o[i]), int'(m_nf(i)));
                chk($sformatf("u%0d not_empty", i), int'(ne_o[i]), int'(m_ne(i)));
                if (mc[i] > 0)
                    chk($sformatf("u%0d first", i), int'(f_o[i]), int'(md[i][0]));
                else if (BYP[i])
                    chk($sformatf("u%0d first_bypass", i), int'(f_o[i]), int'(enq_data));
            end
            @(posedge clk);
            model_update();
        end
    end

    // Drive one cycle of inputs just after the edge, then stop at mid-cycle.
    task automatic step(input logic r, input logic c, input logic e, input logic d,
                        input logic [7:0] dat);
        @(posedge clk);
        #1;
        rst_n = r; clear = c; enq_en = e; deq_en = d; enq_data = dat;
        @(negedge clk);
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("reset count", int'(c_o[0]), 0);
        chk("reset not_full", int'(nf_o[0]), 1);
        chk("reset not_empty", int'(ne_o[0]), 0);

        // Fill depth-3 FIFO, overflow attempt, drain
        step(1, 0, 1, 0, 8'h11);
        step(1, 0, 1, 0, 8'h22);
        chk("fill count1", int'(c_o[0]), 1);
        step(1, 0, 1, 0, 8'h33);
        chk("fill count2", int'(c_o[0]), 2);
        step(1, 0, 1, 0, 8'h44);
        chk("fill count3", int'(c_o[0]), 3);
        chk("fill not_full", int'(nf_o[0]), 0);
        step(1, 0, 0, 1, 8'h00);
        chk("overflow count", int'(c_o[0]), 3);
        chk("drain first0", int'(f_o[0]), 8'h11);
        step(1, 0, 0, 1, 8'h00);
        chk("drain first1", int'(f_o[0]), 8'h22);
        step(1, 0, 0, 1, 8'h00);
        chk("drain first2", int'(f_o[0]), 8'h33);
        step(1, 0, 0, 0, 8'h00);
        chk("drain not_empty", int'(ne_o[0]), 0);

        // Wrap-around with occupancy held at 1
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            step(1, 0, 1, 1, 8'(k));
            chk("wrap first", int'(f_o[0]), k - 1);
        end
        step(1, 0, 0, 1, 8'h00);
        chk("wrap first9", int'(f_o[0]), 9);
        step(1, 0, 0, 0, 8'h00);
        chk("wrap not_empty", int'(ne_o[0]), 0);

        // Pipe vs non-pipe when full (u1 pipe, u2 no pipe)
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 8'h0A);
        step(1, 0, 1, 0, 8'h0B);
        step(1, 0, 1, 1, 8'h0C);
        chk("pipe not_full", int'(nf_o[1]), 1);
        chk("nopipe not_full", int'(nf_o[2]), 0);
        step(1, 0, 0, 1, 8'h00);
        chk("pipe count", int'(c_o[1]), 2);
        chk("pipe first B", int'(f_o[1]), 8'h0B);
        chk("nopipe first B", int'(f_o[2]), 8'h0B);
        chk("nopipe count", int'(c_o[2]), 1);
        step(1, 0, 0, 0, 8'h00);
        chk("pipe first C", int'(f_o[1]), 8'h0C);
        chk("nopipe dropped C", int'(ne_o[2]), 0);

        // Bypass while empty (u3)
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 1, 1, 8'h5A);
        chk("bypass first", int'(f_o[3]), 8'h5A);
        chk("bypass not_empty", int'(ne_o[3]), 1);
        step(1, 0, 0, 0, 8'h00);
        chk("bypass count", int'(c_o[3]), 0);

        // Clear beats enqueue
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 8'h01);
        step(1, 0, 1, 0, 8'h02);
        step(1, 1, 1, 0, 8'h03);
        step(1, 0, 0, 0, 8'h00);
        chk("clear count", int'(c_o[3]), 0);
        chk("clear not_empty", int'(ne_o[3]), 0);
        chk("clear not_full", int'(nf_o[3]), 1);
        step(1, 0, 1, 0, 8'h04);
        step(1, 0, 0, 0, 8'h00);
        chk("clear not stored", int'(f_o[0]), 8'h04);
        chk("clear then count", int'(c_o[0]), 1);

        // Reset mid-stream with a dequeue pending
        step(1, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 8'h01);
        step(1, 0, 1, 0, 8'h02);
        step(0, 0, 0, 1, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        chk("midrst count", int'(c_o[0]), 0);
        step(1, 0, 1, 0, 8'h07);
        step(1, 0, 0, 0, 8'h00);
        chk("midrst first", int'(f_o[0]), 8'h07);

        // Mixed traffic, checked by the per-cycle model only
        for (int k = 0; k < 150; k++)
            step(1, ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 8'($urandom));

        step(1, 0, 0, 0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mk_sized_fifo.md
# mk_sized_fifo

Parametrised synchronous FIFO for clock-domain-local buffering between pipeline stages. It generalises the single register primitive to a configurable depth of storage entries. Guarded enqueue and dequeue interfaces expose readiness and occupancy. Optional pipeline and bypass modes allow back-to-back flow without bubbles.

## Interface
- width, 1: data width in bits.
- depth, 2: number of storage entries; legal range 1..256, need not be a power of two.
- pipe, 0: 1 = enqueue accepted when full if a dequeue occurs in the same cycle.
- bypass, 0: 1 = dequeue accepted when empty if an enqueue occurs in the same cycle; data passes through combinationally.
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous flush; empties the FIFO.
- enq_en  input  1  enqueue request.
- enq_data  input  width  data to enqueue.
- deq_en  input  1  dequeue request.
- first  output  width  head-of-queue data.
- not_full  output  1  enqueue will be accepted this cycle.
- not_empty  output  1  first is valid and dequeue will be accepted this cycle.
- count  output  CW  occupancy, where CW = $clog2(depth+1).

## Operation
- State:
  - storage array of depth × width;
  - head and tail pointers in 0..depth-1;
  - count register.
  - Storage is not reset. In simulation it is initialised to the alternating 1010… pattern, truncated to width.
- Pointers advance by 1 and wrap from depth-1 to 0. No power-of-two masking.
- full = (count == depth); empty = (count == 0).
- Enqueue acceptance:
  - can_enq = !full || (pipe && deq_en && !empty).
  - not_full = can_enq.
  - With pipe=1, a combinational path from deq_en to not_full is intended.
- Dequeue acceptance:
  - can_deq = !empty || (bypass && enq_en).
  - not_empty = can_deq.
- Data output:
  - first = storage[head] when !empty.
  - first = enq_data when empty and bypass=1.
  - Otherwise first is storage[head], content undefined.
- Per-cycle update, in priority order:
  1. !rst_n: head=0, tail=0, count=0.
  2. clear: same as reset; enq_en and deq_en are ignored that cycle.
  3. Effective enq = enq_en && can_enq. Effective deq = deq_en && can_deq.
  4. Bypass case (empty, bypass=1, both effective): nothing is written; pointers and count are unchanged.
  5. Otherwise:
     - effective enq writes storage[tail] and advances tail;
     - effective deq advances head;
     - count += enq − deq, so simultaneous enq and deq leave count unchanged.
- Requests that are not accepted are dropped silently with no state change. Checkers flag them as protocol violations.

## Timing
- Reset values: not_full=1, not_empty=0, count=0; first undefined.
- Same values one cycle after clear.
- Enqueue-to-first latency:
  - 1 cycle (data visible the cycle after the enq edge);
  - 0 cycles in the bypass case.
- count, not_full and not_empty reflect registered state plus the combinational pipe and bypass terms only.
- depth=1 with pipe=1 sustains one transfer per cycle. depth=1 with pipe=0 sustains one transfer every 2 cycles.
- Reset or clear while full discards all entries. The next enqueued item appears at first one cycle after its enqueue.

## Test plan
- Reset, then fill: width=8, depth=3, enqueue 0x11, 0x22, 0x33 on consecutive cycles.
  - Expect count 1, 2, 3 and not_full=0 after the third.
  - A fourth enq of 0x44 is dropped and count stays 3.
  - Dequeue three times: first = 0x11, 0x22, 0x33, then not_empty=0.
- Wrap-around: depth=3, run 10 enq/deq pairs with data 0..9, keeping occupancy at 1–2.
  - Output order is exactly 0..9 and count never exceeds 3.
- Pipe mode: pipe=1, depth=2, full with 0xA, 0xB.
  - Assert deq_en and enq_en with 0xC in the same cycle: not_full=1 in that cycle, count stays 2.
  - first shows 0xB, then 0xC.
  - The same stimulus with pipe=0 drops 0xC.
- Bypass mode: bypass=1, empty, enq_en=deq_en=1 with enq_data=0x5A.
  - first=0x5A and not_empty=1 in the same cycle; count remains 0 afterwards.
- Clear priority: depth=4 holding 2 entries, assert clear with enq_en=1.
  - Next cycle count=0, not_empty=0, not_full=1, and the enqueued data is not stored.
- Reset mid-stream: rst_n=0 for one cycle while count=2 and deq_en=1.
  - Next cycle count=0.
  - A subsequent enq of 0x7 gives first=0x7 one cycle later.
